// File: rtl/pipe_stage_reg.sv
// Purpose : one pipeline stage register for a packed payload with valid/ready handshake, flush and stall counter.
// Latency : 1 cycle from push to out_valid/out_data.
// Backpressure: holds the payload while out_ready=0. Without the skid buffer, in_ready is !out_valid || out_ready.
//               With the skid buffer, in_ready is decoded from the state flop and one extra payload is parked.
//
// Optional feature: define PIPE_STAGE_SKID_EN to build in the two-entry skid buffer (states EMPTY/FULL/SKID).
//
// Ports:
//   clk, reset_n          clock; asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_data               upstream payload
//   out_valid/out_ready   downstream handshake
//   out_data              registered payload (NOP_VAL after reset/flush)
//   flush                 synchronous squash of every held payload
//   stall_cnt             saturating count of edges with out_valid=1 and out_ready=0
module pipe_stage_reg #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  NOP_VAL = '0,
    parameter int                 CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                push;
    logic                pop;

    // Both SKID and FULL present a valid payload; SKID only adds the parked one.
    assign out_valid = (state != EMPTY);

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0]   skid_data;
    logic [DATA_W-1:0]   skid_nxt;

    // Decoded from the state flop only, so no combinational path from out_ready.
    assign in_ready = (state != SKID);
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        data_nxt  = out_data;
        cnt_nxt   = stall_cnt;
`ifdef PIPE_STAGE_SKID_EN
        skid_nxt  = skid_data;
`endif

        // Stall accounting runs regardless of flush.
        if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            cnt_nxt = stall_cnt + CNT_ONE;
        end

        if (flush) begin
            state_nxt = EMPTY;
            data_nxt  = NOP_VAL;
`ifdef PIPE_STAGE_SKID_EN
            skid_nxt  = NOP_VAL;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt = FULL;
                        data_nxt  = in_data;
                    end
                end
                FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (push && !pop) begin
                        // Output is blocked: park the newcomer behind it.
                        state_nxt = SKID;
                        skid_nxt  = in_data;
                    end else if (push && pop) begin
                        data_nxt  = in_data;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
`else
                    if (push) begin
                        data_nxt  = in_data;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                SKID: begin
                    // in_ready is low here, so no push can arrive.
                    if (pop) begin
                        state_nxt = FULL;
                        data_nxt  = skid_data;
                    end
                end
`endif
                default: begin
                    state_nxt = EMPTY;
                    data_nxt  = NOP_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            out_data  <= NOP_VAL;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            out_data  <= data_nxt;
            stall_cnt <= cnt_nxt;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_data <= NOP_VAL;
        end else begin
            skid_data <= skid_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg (DATA_W=8, CNT_W=4, NOP_VAL=8'hC3).
// Each table row is one clock: inputs driven after the falling edge, in_ready checked before
// the rising edge, registered outputs checked at the following falling edge.
module tb_pipe_stage_reg;

    localparam int          DW  = 8;
    localparam int          CW  = 4;
    localparam logic [7:0]  NOP = 8'hC3;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID_BUILD = 1'b1;
`else
    localparam bit SKID_BUILD = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic [CW-1:0] stall_cnt;

    int n_cmp;
    int n_err;

    pipe_stage_reg #(
        .DATA_W  (DW),
        .NOP_VAL (NOP),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic       chk_od;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string tag, logic iv, logic [7:0] d, logic ordy, logic fl,
                                logic e_ir, logic e_ov, logic [7:0] e_od, logic chk_od,
                                logic [3:0] e_cnt);
        vec_t v;
        v.tag = tag; v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.chk_od = chk_od; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic iv, logic [7:0] d, logic ordy, logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic run_vec(vec_t v, int idx);
        string nm;
        nm = $sformatf("%s[%0d]", v.tag, idx);
        drive(v.iv, v.d, v.ordy, v.fl);
        #1;
        chk({nm, ".in_ready"}, 32'(in_ready), 32'(v.e_ir));
        @(posedge clk);
        @(negedge clk);
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
        if (v.chk_od) chk({nm, ".out_data"}, 32'(out_data), 32'(v.e_od));
        chk({nm, ".stall_cnt"}, 32'(stall_cnt), 32'(v.e_cnt));
    endtask

    initial begin
        logic       hold_ir;
        logic [3:0] sat;
        n_cmp = 0;
        n_err = 0;
        hold_ir = SKID_BUILD;   // in_ready while FULL and out_ready=0

        // ---------------- table ----------------
        // Single push then a back-to-back stream 0x11..0x1F, one pop per cycle.
        vecs.push_back(mk("first", 1, 8'h11, 1, 0, 1, 1, 8'h11, 1, 0));
        for (int i = 8'h12; i <= 8'h1F; i++)
            vecs.push_back(mk("stream", 1, 8'(i), 1, 0, 1, 1, 8'(i), 1, 0));
        vecs.push_back(mk("drain", 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
        // Push 0xAA and hold it for 5 stalled edges, then pop.
        vecs.push_back(mk("hold_push", 1, 8'hAA, 0, 0, 1, 1, 8'hAA, 1, 0));
        for (int k = 1; k <= 5; k++)
            vecs.push_back(mk("hold", 0, 8'h00, 0, 0, hold_ir, 1, 8'hAA, 1, 4'(k)));
        vecs.push_back(mk("hold_pop", 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 5));
        // Flush while stalled: payload squashed, stall_cnt still advances.
        vecs.push_back(mk("fl_push", 1, 8'h01, 0, 0, 1, 1, 8'h01, 1, 5));
        vecs.push_back(mk("fl_stall", 1, 8'h02, 0, 1, hold_ir, 0, NOP, 1, 6));
        vecs.push_back(mk("fl_after", 0, 8'h00, 1, 0, 1, 0, NOP, 1, 6));
        // Flush on an edge with push and pop: push discarded.
        vecs.push_back(mk("fl2_push", 1, 8'h03, 1, 0, 1, 1, 8'h03, 1, 6));
        vecs.push_back(mk("fl2_pp", 1, 8'h04, 1, 1, 1, 0, NOP, 1, 6));
        vecs.push_back(mk("fl2_after", 0, 8'h00, 1, 0, 1, 0, NOP, 1, 6));
        // Stall counter saturation at 15.
        vecs.push_back(mk("sat_push", 1, 8'h55, 0, 0, 1, 1, 8'h55, 1, 6));
        for (int k = 1; k <= 20; k++) begin
            sat = (6 + k > 15) ? 4'd15 : 4'(6 + k);
            vecs.push_back(mk("sat", 0, 8'h00, 0, 0, hold_ir, 1, 8'h55, 1, sat));
        end
        vecs.push_back(mk("sat_pop", 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 15));

        // ---------------- reset ----------------
        drive(0, 8'h00, 0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.out_data", 32'(out_data), 32'(NOP));
        chk("rst.stall_cnt", 32'(stall_cnt), 0);
        chk("rst.in_ready", 32'(in_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_rel.in_ready", 32'(in_ready), 1);

        // ---------------- table run ----------------
        foreach (vecs[i]) run_vec(vecs[i], i);

        // ---------------- async reset mid-stream ----------------
        drive(1, 8'h77, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("amr.pre_ov", 32'(out_valid), 1);
        chk("amr.pre_od", 32'(out_data), 32'h77);
        #2;
        reset_n = 1'b0;
        #1;
        chk("amr.out_valid", 32'(out_valid), 0);
        chk("amr.out_data", 32'(out_data), 32'(NOP));
        chk("amr.stall_cnt", 32'(stall_cnt), 0);
        chk("amr.in_ready", 32'(in_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 8'h88, 1, 0);
        @(posedge clk);
        @(negedge clk);
        chk("amr.post_ov", 32'(out_valid), 1);
        chk("amr.post_od", 32'(out_data), 32'h88);
        drive(0, 8'h00, 1, 0);
        @(posedge clk);
        @(negedge clk);
        chk("amr.post_drain", 32'(out_valid), 0);

`ifdef PIPE_STAGE_SKID_EN
        // ---------------- skid ordering ----------------
        drive(1, 8'h01, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("skid.ov1", 32'(out_valid), 1);
        chk("skid.od1", 32'(out_data), 32'h01);
        chk("skid.ir1", 32'(in_ready), 1);
        drive(1, 8'h02, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("skid.ir_full", 32'(in_ready), 0);
        chk("skid.od_hold", 32'(out_data), 32'h01);
        drive(0, 8'h00, 1, 0);
        #1;
        chk("skid.ir_no_comb", 32'(in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("skid.ov2", 32'(out_valid), 1);
        chk("skid.od2", 32'(out_data), 32'h02);
        @(posedge clk);
        @(negedge clk);
        chk("skid.empty", 32'(out_valid), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
